// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory and loads the IF/ID register feeding decode.
// A one-entry skid buffer absorbs decode stalls, a taken-branch flush
// redirects the PC (abandoning an outstanding fetch via the DROP state), and
// a fetched HLT instruction parks the stage in HALT until the next redirect.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | normal fetching; request whenever the skid buffer is empty
// DROP  | holding an abandoned request until memory answers; data discarded
// HALT  | HLT fetched; no requests, PC frozen until a flush redirects
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OP   = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] br_tgt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] if_id_instr,
    output logic [3:0]  if_id_opcode,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_vld,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_drop_addr;

    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc2;
    logic        r_buf_vld;

    logic [15:0] r_if_id_instr;
    logic [15:0] r_if_id_pc2;
    logic        r_if_id_vld;

    logic        w_in_fetch;
    logic        w_in_drop;
    logic        w_capture;
    logic        w_cap_hlt;
    logic        w_abandon;
    logic [15:0] w_pc_plus2;
    logic [15:0] w_tgt;

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_in_drop  = (r_state == ST_DROP);

    // A full skid buffer blocks new requests so at most one un-consumed
    // instruction is ever held outside IF/ID.
    assign imem_req   = rst_n & ((w_in_fetch & ~r_buf_vld) | w_in_drop);
    assign imem_addr  = w_in_drop ? r_drop_addr : r_pc;

    // Data returned in a flush cycle belongs to the wrong path and is dropped.
    assign w_capture  = w_in_fetch & imem_req & imem_rdy & ~flush;
    assign w_cap_hlt  = w_capture & (imem_data[15:12] == HLT_OP);

    // A request still waiting on memory cannot be withdrawn; remember its
    // address so it can be held until the response arrives.
    assign w_abandon  = flush & w_in_fetch & imem_req & ~imem_rdy;

    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_tgt      = br_tgt & 16'hFFFE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: flush wins over HLT capture; DROP leaves only on the
    // abandoned response, regardless of further flushes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (flush) begin
                    w_state_nxt = w_abandon ? ST_DROP : ST_FETCH;
                end else if (w_cap_hlt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_DROP: begin
                if (imem_rdy) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // PC and abandoned-request address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_drop_addr <= 16'h0000;
        end else begin
            if (flush) begin
                r_pc <= w_tgt;
            end else if (w_capture) begin
                r_pc <= w_pc_plus2;
            end
            if (w_abandon) begin
                r_drop_addr <= r_pc;
            end
        end
    end

    // Skid buffer: filled by a capture during stall, drained on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_instr <= 16'h0000;
            r_buf_pc2   <= 16'h0000;
            r_buf_vld   <= 1'b0;
        end else if (flush) begin
            r_buf_vld <= 1'b0;
        end else if (stall) begin
            if (w_capture) begin
                r_buf_instr <= imem_data;
                r_buf_pc2   <= w_pc_plus2;
                r_buf_vld   <= 1'b1;
            end
        end else begin
            r_buf_vld <= 1'b0;
        end
    end

    // IF/ID register: buffer has priority over fresh data so order is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id_instr <= 16'h0000;
            r_if_id_pc2   <= 16'h0000;
            r_if_id_vld   <= 1'b0;
        end else if (flush) begin
            r_if_id_vld <= 1'b0;
        end else if (!stall) begin
            if (r_buf_vld) begin
                r_if_id_instr <= r_buf_instr;
                r_if_id_pc2   <= r_buf_pc2;
                r_if_id_vld   <= 1'b1;
            end else if (w_capture) begin
                r_if_id_instr <= imem_data;
                r_if_id_pc2   <= w_pc_plus2;
                r_if_id_vld   <= 1'b1;
            end else begin
                r_if_id_vld <= 1'b0;
            end
        end
    end

    assign if_id_instr    = r_if_id_instr;
    assign if_id_opcode   = r_if_id_instr[15:12];
    assign if_id_pc_plus2 = r_if_id_pc2;
    assign if_id_vld      = r_if_id_vld;
    assign halted         = (r_state == ST_HALT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It owns the PC, runs a ready/valid-style handshake with a variable-latency instruction memory, and loads the IF/ID pipeline register whose opcode and valid bit drive the decode-stage control unit. It absorbs hazard stalls through a one-entry skid buffer, handles taken-branch redirects (including discarding an in-flight fetch), and stops fetching after a HLT instruction.

## Interface
- RESET_PC, 16'h0000, PC value loaded at reset
- HLT_OP, 4'hF, opcode that halts fetch
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard stall from decode: hold IF/ID and PC
- flush  in  1  taken branch resolved in decode: kill IF/ID, redirect
- br_tgt  in  16  redirect address, valid with flush; bit 0 forced to 0
- imem_req  out  1  fetch request; addr must stay stable while req=1 and imem_rdy=0
- imem_addr  out  16  fetch address
- imem_rdy  in  1  data valid for current request (may be high in the request cycle)
- imem_data  in  16  fetched instruction
- if_id_instr  out  16  registered instruction
- if_id_opcode  out  4  if_id_instr[15:12]
- if_id_pc_plus2  out  16  address of instruction + 2
- if_id_vld  out  1  IF/ID holds a live instruction (control unit vld)
- halted  out  1  fetch stopped on HLT

## Operation
- Registers: pc, state, drop_addr, buf_instr/buf_pc2/buf_vld, IF/ID (instr, pc_plus2, vld).
- States: FETCH (normal), DROP (discarding abandoned request), HALT (no fetch).
- imem_req = rst_n & ((FETCH & ~buf_vld) | DROP). imem_addr = pc in FETCH, drop_addr in DROP.
- Capture = FETCH & imem_req & imem_rdy & ~flush. Captured pc2 = pc + 2 (mod 2^16); pc <= pc + 2 on capture.
- IF/ID update, priority order:
  - flush: if_id_vld<=0, buf_vld<=0, pc<=br_tgt&~1. If FETCH with req=1 and imem_rdy=0: drop_addr<=pc, go DROP. From HALT: go FETCH, halted<=0. If imem_rdy=1 that cycle: data discarded, stay/go FETCH.
  - stall: IF/ID holds. Capture goes to buffer (buf_vld<=1).
  - no stall: buf_vld=1 -> IF/ID<=buffer, vld=1, buf_vld<=0; else capture -> IF/ID<=data, vld=1; else if_id_vld<=0 (bubble).
- HLT: captured instruction with opcode HLT_OP (into IF/ID or buffer) moves state to HALT; HLT itself is delivered with vld=1 so downstream drains. HALT: req=0, pc frozen, IF/ID follows stall/bubble rules, halted=1.
- DROP: hold req, addr=drop_addr until imem_rdy; that data is discarded; next state FETCH at redirected pc. Further flush in DROP updates pc only, stays DROP.
- Reset (any time, including mid-request or mid-DROP): pc=RESET_PC, state=FETCH, buf_vld=0, if_id_vld=0, if_id_instr=0, if_id_pc_plus2=0, halted=0, imem_req=0 while rst_n low; in-flight memory response after reset is memory's responsibility.

## Timing
- Zero-wait memory: instruction at address A is in IF/ID one edge after the request cycle; sustained 1 instruction/cycle.
- N-wait memory: IF/ID vld=0 for N bubbles per instruction.
- Stall release with buffer full: buffer moves to IF/ID that edge; next request issued the following cycle (one bubble).
- Flush: IF/ID invalid the edge after flush; first request to br_tgt issued the cycle after flush (FETCH) or the cycle after abandoned imem_rdy (DROP).
- halted rises the edge HLT is captured; no request the following cycle.

## Test plan
- Zero-wait, RESET_PC=0, memory returns 16'h1123,16'h2234,...: IF/ID shows 0x1123/pc2=2, then 0x2234/pc2=4 on consecutive cycles, vld=1 throughout.
- 2-wait memory: req held with addr=0x0000 stable 3 cycles; if_id_vld toggles 0,0,1 pattern; pc_plus2 increments by 2 per instruction.
- stall=1 for 3 cycles while imem_rdy returns 0xA5A5: IF/ID unchanged, req drops after capture; stall=0 -> IF/ID=0xA5A5, next req the cycle after.
- 3-wait memory, flush with br_tgt=0x0041 one cycle after req to 0x0010: req stays at 0x0010 until rdy, data discarded, next req addr=0x0040, if_id_vld=0 meanwhile.
- Fetch 0xF000 at 0x0008: IF/ID=0xF000 vld=1, halted=1, req=0 thereafter; flush with br_tgt=0x0020 -> halted=0, req at 0x0020.
- rst_n low mid-DROP: all outputs to reset values asynchronously; after release first req addr=RESET_PC.
